// File: rtl/uart_tx_fifo_if.sv
// Valid/ready word stream carrying words into uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a word FIFO in front: 5-8 data bits, optional parity, 1 or 2 stop bits.
// Frames are sent back to back while the FIFO holds words.
module uart_tx_fifo #(
  parameter int unsigned FREQUENCY = 50_000_000,
  parameter int unsigned BPS       = 115_200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  uart_tx_fifo_if.slave          s_if,
  output logic                   serial_out,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned Divisor = FREQUENCY / BPS;
  localparam int unsigned AddrW   = $clog2(DEPTH);
  localparam int unsigned TimerW  = (Divisor > 2) ? $clog2(Divisor) : 1;

  localparam logic [AddrW:0]    FullLevel = (AddrW + 1)'(DEPTH);
  localparam logic [TimerW-1:0] BitLast   = TimerW'(Divisor - 1);
  localparam logic [2:0]        DataLast  = 3'(DATA_BITS - 1);
  localparam logic [2:0]        StopLast  = 3'(STOP_BITS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : gen_chk_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..8");
  end
  if (PARITY > 2) begin : gen_chk_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_chk_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (Divisor < 2) begin : gen_chk_divisor
    $error("uart_tx_fifo: FREQUENCY / BPS must be at least 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_chk_depth
    $error("uart_tx_fifo: DEPTH must be a power of two, at least 2");
  end

  // FIFO
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]       count_q, count_d;
  logic                 push, pop, fifo_empty;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  assign s_if.tready = (count_q != FullLevel);
  assign push        = s_if.tvalid && s_if.tready;
  assign fifo_empty  = (count_q == '0);
  assign head        = mem_q[rd_ptr_q];
  // Parity bit that brings the ones count of data+parity to odd (1) or even (2).
  assign head_par    = (PARITY == 1) ? ~^head : ^head;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_if.tdata;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Serialiser
  logic [2:0]           state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 serial_q, serial_d;
  logic                 bit_end, load;

  assign bit_end = (timer_q == BitLast);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    serial_d  = serial_q;
    load      = 1'b0;
    pop       = 1'b0;

    if (state_q != StIdle) begin
      timer_d = bit_end ? '0 : timer_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        load = !fifo_empty;
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
          serial_d  = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_cnt_q != DataLast) begin
            shift_d   = shift_q >> 1;
            serial_d  = shift_q[1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (PARITY != 0) begin
            state_d  = StParity;
            serial_d = par_q;
          end else begin
            state_d  = StStop;
            serial_d = 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d   = StStop;
          bit_cnt_d = '0;
          serial_d  = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_cnt_q != StopLast) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d  = StIdle;
        timer_d  = '0;
        serial_d = 1'b1;
      end
    endcase

    // Next frame starts straight from idle or from the last stop bit.
    if (load) begin
      pop      = 1'b1;
      shift_d  = head;
      par_d    = head_par;
      serial_d = 1'b0;
      state_d  = StStart;
      timer_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      serial_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      serial_q  <= serial_d;
    end
  end

  assign serial_out = serial_q;
  assign level      = count_q;
  assign busy       = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8N1, 7E1, 7O2) at divisor 8, depth 4, each
// checked every cycle against a queue-based line model, plus directed frame/reset checks.
module tb_uart_tx_fifo;

  localparam int NumDut = 3;
  localparam int Div    = 8;
  localparam int CapLen = 400;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       tvalid   [NumDut];
  logic [7:0] tdata    [NumDut];
  logic       tready_w [NumDut];
  logic       serial_w [NumDut];
  logic       busy_w   [NumDut];
  logic [7:0] level_w  [NumDut];

  int errors = 0;
  int checks = 0;

  logic cap    [NumDut][CapLen];
  int   busy_n [NumDut];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NumDut; g++) begin : gen_dut
    localparam int Db    = (g == 0) ? 8 : 7;
    localparam int Par   = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
    localparam int Stop  = (g == 2) ? 2 : 1;
    localparam int Depth = 4;

    uart_tx_fifo_if #(.DATA_BITS(Db)) bus ();
    logic [2:0] level;

    assign bus.tvalid  = tvalid[g];
    assign bus.tdata   = tdata[g][Db-1:0];
    assign tready_w[g] = bus.tready;
    assign level_w[g]  = {5'd0, level};

    uart_tx_fifo #(
      .FREQUENCY(800),
      .BPS      (100),
      .DATA_BITS(Db),
      .PARITY   (Par),
      .STOP_BITS(Stop),
      .DEPTH    (Depth)
    ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .s_if      (bus),
      .serial_out(serial_w[g]),
      .busy      (busy_w[g]),
      .level     (level)
    );

    // Reference: accepted words wait in word_q; the line is a per-cycle queue of frame bits.
    logic [7:0] word_q [$];
    logic       cyc_q  [$];

    always @(negedge clock) begin
      logic [7:0]  w;
      logic [10:0] got, exp;
      logic        pb;
      if (!reset_n) begin
        word_q.delete();
        cyc_q.delete();
      end
      got = {serial_w[g], busy_w[g], tready_w[g], level_w[g]};
      exp = {(cyc_q.size() > 0) ? cyc_q[0] : 1'b1,
             (word_q.size() > 0) || (cyc_q.size() > 0),
             word_q.size() < Depth,
             8'(word_q.size())};
      check($sformatf("u%0d line/busy/tready/level", g), int'(got), int'(exp));
      if (reset_n) begin
        if (cyc_q.size() > 0) void'(cyc_q.pop_front());
        if (cyc_q.size() == 0 && word_q.size() > 0) begin
          w  = word_q.pop_front();
          pb = (Par == 1) ? ($countones(w) % 2 == 0) : ($countones(w) % 2 == 1);
          for (int r = 0; r < Div; r++) cyc_q.push_back(1'b0);
          for (int i = 0; i < Db; i++)
            for (int r = 0; r < Div; r++) cyc_q.push_back(w[i]);
          if (Par != 0)
            for (int r = 0; r < Div; r++) cyc_q.push_back(pb);
          for (int r = 0; r < Stop * Div; r++) cyc_q.push_back(1'b1);
        end
        if (tvalid[g] && tready_w[g]) word_q.push_back(tdata[g] & 8'((1 << Db) - 1));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic capture(input int ncyc);
    for (int g = 0; g < NumDut; g++) busy_n[g] = 0;
    for (int k = 0; k < ncyc; k++) begin
      for (int g = 0; g < NumDut; g++) begin
        cap[g][k] = serial_w[g];
        if (busy_w[g]) busy_n[g]++;
      end
      step(1);
    end
  endtask

  task automatic wait_idle(input int g);
    int t = 0;
    while (busy_w[g] && t < 3000) begin
      step(1);
      t++;
    end
    check($sformatf("u%0d drain", g), int'(busy_w[g]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] f55;
    logic       offer_lost [NumDut];
    int         n, t, run, lows;

    for (int g = 0; g < NumDut; g++) begin
      tvalid[g] = 1'b0;
      tdata[g]  = 8'h00;
    end
    step(2);
    for (int g = 0; g < NumDut; g++)
      check($sformatf("u%0d reset", g),
            int'({serial_w[g], busy_w[g], tready_w[g], level_w[g]}), int'(11'b1_0_1_00000000));
    reset_n = 1'b1;
    step(2);

    // One word into each instance on the same edge: shape, parity, busy length.
    tdata[0] = 8'h55;
    tdata[1] = 8'h07;
    tdata[2] = 8'h07;
    for (int g = 0; g < NumDut; g++) tvalid[g] = 1'b1;
    step(1);
    for (int g = 0; g < NumDut; g++) tvalid[g] = 1'b0;
    check("u0 level after accept", int'(level_w[0]), 1);
    capture(200);
    check("u0 busy cycles", busy_n[0], 81);
    check("u1 busy cycles", busy_n[1], 81);
    check("u2 busy cycles", busy_n[2], 89);
    check("u0 idle before pop", int'(cap[0][0]), 1);
    check("u0 start edge", int'(cap[0][1]), 0);
    f55 = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++)
      check($sformatf("u0 bit%0d", b), int'(cap[0][1 + b * Div + 4]), int'(f55[b]));
    check("u1 even parity", int'(cap[1][69]), 1);
    check("u2 odd parity", int'(cap[2][69]), 0);

    // Two stop bits, back-to-back words; second push coincides with the first pop.
    tvalid[2] = 1'b1;
    tdata[2]  = 8'h01;
    step(1);
    tdata[2] = 8'h02;
    step(1);
    tvalid[2] = 1'b0;
    check("u2 level push+pop", int'(level_w[2]), 1);
    capture(250);
    check("u2 parity before stop", int'(cap[2][71]), 0);
    run = 0;
    while (run < 40 && cap[2][72 + run]) run++;
    check("u2 stop gap", run, 16);
    wait_idle(2);

    // Hold tvalid with six words at depth 4.
    tvalid[0] = 1'b1;
    tdata[0]  = 8'hA0;
    n = 0;
    t = 0;
    while (n < 6 && t < 2000) begin
      offer_lost[0] = !tready_w[0];
      step(1);
      t++;
      if (!offer_lost[0]) begin
        n++;
        tdata[0] = 8'hA0 + 8'(n);
      end
    end
    tvalid[0] = 1'b0;
    check("u0 six words accepted", n, 6);
    wait_idle(0);

    // Reset during data bit 3 with a second word queued.
    tvalid[0] = 1'b1;
    tdata[0]  = 8'h3C;
    step(1);
    tdata[0] = 8'hC3;
    step(1);
    tvalid[0] = 1'b0;
    step(35);
    reset_n = 1'b0;
    #1;
    check("u0 reset line", int'(serial_w[0]), 1);
    check("u0 reset level", int'(level_w[0]), 0);
    check("u0 reset busy", int'(busy_w[0]), 0);
    step(3);
    reset_n = 1'b1;
    capture(300);
    for (int g = 0; g < NumDut; g++) begin
      lows = 0;
      for (int k = 0; k < 300; k++) if (!cap[g][k]) lows++;
      check($sformatf("u%0d quiet after reset", g), lows, 0);
      check($sformatf("u%0d busy after reset", g), busy_n[g], 0);
    end

    // Toggling tvalid with random data against a mostly full FIFO.
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < NumDut; g++) offer_lost[g] = tvalid[g] && !tready_w[g];
      step(1);
      for (int g = 0; g < NumDut; g++) begin
        tvalid[g] = ~tvalid[g];
        if (!offer_lost[g]) tdata[g] = 8'($urandom);
      end
    end
    for (int g = 0; g < NumDut; g++) tvalid[g] = 1'b0;
    for (int g = 0; g < NumDut; g++) wait_idle(g);
    step(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
